// File: rtl/fifo_sequencer_if.sv
// Signal bundle for fifo_sequencer: FPC command FIFO, TPC response FIFO and the
// local register bus. The sequencer takes the master side.
interface fifo_sequencer_if #(
   parameter int ABITS = 16
);
   logic             fpc_valid;
   logic [63:0]      fpc_data;
   logic             fpc_read;
   logic             tpc_ready;
   logic             tpc_write;
   logic [63:0]      tpc_data;
   logic             rvalid;
   logic             wvalid;
   logic [ABITS-1:0] address;
   logic [63:0]      wdata;
   logic [63:0]      rdata;
   logic [15:0]      status;

   modport master (
      input  fpc_valid, fpc_data, tpc_ready, rdata, status,
      output fpc_read, tpc_write, tpc_data, rvalid, wvalid, address, wdata
   );

   modport slave (
      output fpc_valid, fpc_data, tpc_ready, rdata, status,
      input  fpc_read, tpc_write, tpc_data, rvalid, wvalid, address, wdata
   );
endinterface

// File: rtl/fifo_sequencer.sv
// Command sequencer: pulls 64-bit commands from the FPC FIFO, drives single-cycle
// register-bus reads/writes and pushes read data / status words into the TPC FIFO.
module fifo_sequencer #(
   parameter int ABITS = 16,
   parameter int RLAT  = 2
) (
   input logic              clock,
   input logic              reset,
   fifo_sequencer_if.master bus
);
   typedef enum logic [2:0] {FETCH, WDATA, RWAIT, DELAY, RESP} state_t;

   localparam logic [3:0] OP_WRITE  = 4'd1;
   localparam logic [3:0] OP_READ   = 4'd2;
   localparam logic [3:0] OP_STATUS = 4'd3;
   localparam logic [3:0] OP_DELAY  = 4'd4;

   state_t           state_q, state_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [ABITS-1:0] addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      tpc_data_q, tpc_data_d;
   logic             rvalid_q, rvalid_d;
   logic             wvalid_q, wvalid_d;
   logic             tpc_write_q, tpc_write_d;
   logic             accept;

   logic [3:0]       op;
   logic [ABITS-1:0] cmd_addr;
   logic [31:0]      cmd_arg;
   logic             needs_room;

   assign op         = bus.fpc_data[63:60];
   assign cmd_addr   = bus.fpc_data[ABITS+31:32];
   assign cmd_arg    = bus.fpc_data[31:0];
   // Commands that will push a response may only start once TPC space is guaranteed.
   assign needs_room = (op == OP_READ) || (op == OP_STATUS);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      tpc_data_d  = tpc_data_q;
      rvalid_d    = 1'b0;
      wvalid_d    = 1'b0;
      tpc_write_d = 1'b0;
      accept      = 1'b0;

      unique case (state_q)
         FETCH: begin
            if (bus.fpc_valid && (!needs_room || bus.tpc_ready)) begin
               accept = 1'b1;
               case (op)
                  OP_WRITE: begin
                     addr_d  = cmd_addr;
                     state_d = WDATA;
                  end
                  OP_READ: begin
                     addr_d   = cmd_addr;
                     rvalid_d = 1'b1;
                     cnt_d    = 32'(RLAT);
                     state_d  = RWAIT;
                  end
                  OP_STATUS: begin
                     tpc_data_d  = {48'h0, bus.status};
                     tpc_write_d = 1'b1;
                     state_d     = RESP;
                  end
                  OP_DELAY: begin
                     cnt_d   = cmd_arg;
                     state_d = DELAY;
                  end
                  default: ;
               endcase
            end
         end
         WDATA: begin
            if (bus.fpc_valid) begin
               accept   = 1'b1;
               wdata_d  = bus.fpc_data;
               wvalid_d = 1'b1;
               state_d  = RESP;
            end
         end
         RWAIT: begin
            // Counter reaches zero in the cycle rdata is valid on the bus.
            if (cnt_q == 32'd0) begin
               tpc_data_d  = bus.rdata;
               tpc_write_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         DELAY: begin
            if (cnt_q <= 32'd1) begin
               cnt_d   = 32'd0;
               state_d = FETCH;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         RESP: state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= FETCH;
         cnt_q       <= 32'd0;
         addr_q      <= '0;
         wdata_q     <= 64'h0;
         tpc_data_q  <= 64'h0;
         rvalid_q    <= 1'b0;
         wvalid_q    <= 1'b0;
         tpc_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tpc_data_q  <= tpc_data_d;
         rvalid_q    <= rvalid_d;
         wvalid_q    <= wvalid_d;
         tpc_write_q <= tpc_write_d;
      end
   end

   assign bus.fpc_read  = accept & ~reset;
   assign bus.tpc_write = tpc_write_q;
   assign bus.tpc_data  = tpc_data_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.wvalid    = wvalid_q;
   assign bus.address   = addr_q;
   assign bus.wdata     = wdata_q;
endmodule

// File: tb/tb_fifo_sequencer.sv
// Randomized bench for fifo_sequencer: a FIFO source, a register peripheral with
// RLAT read latency, and a command-stream reference model with cycle-timed events.
module tb_fifo_sequencer;
   localparam int ABITS = 16;
   localparam int RLAT  = 2;

   typedef struct {
      int          c;
      logic [63:0] a;
      logic [63:0] d;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   fifo_sequencer_if #(.ABITS(ABITS)) bus ();
   fifo_sequencer #(.ABITS(ABITS), .RLAT(RLAT)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ready_cyc = 0;
   int unsigned vld_pct = 100;
   int unsigned rdy_pct = 100;
   logic        st_force = 1'b0;
   logic        want_data = 1'b0;
   logic [63:0] wr_addr = 64'h0;
   logic [63:0] src_q[$];
   logic [63:0] push_log[$];
   int          cons_cyc[$];
   ev_t         exp_w[$];
   ev_t         exp_r[$];
   ev_t         exp_t[$];
   logic [63:0] ref_mem [0:255];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Register peripheral: writes land on wvalid, read data appears RLAT cycles after rvalid.
   logic [63:0] regs [0:255];
   logic [63:0] rdp [0:RLAT-1];
   logic        mem_init = 1'b0;
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) regs[i] <= 64'h0;
         mem_init <= 1'b1;
      end else if (bus.wvalid) begin
         regs[bus.address[7:0]] <= bus.wdata;
      end
      rdp[0] <= bus.rvalid ? regs[bus.address[7:0]] : 64'h0;
      for (int i = 1; i < RLAT; i++) rdp[i] <= rdp[i-1];
   end
   assign bus.rdata = rdp[RLAT-1];

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial begin
      bus.fpc_valid = 1'b0;
      bus.fpc_data  = 64'h0;
      bus.tpc_ready = 1'b0;
      bus.status    = 16'h0;
      forever begin
         @(posedge clock);
         #1;
         bus.fpc_valid = (src_q.size() != 0) && ($urandom_range(99) < vld_pct);
         bus.fpc_data  = (src_q.size() != 0) ? src_q[0] : 64'h0;
         bus.tpc_ready = ($urandom_range(99) < rdy_pct);
         bus.status    = st_force ? 16'hA5C3 : 16'($urandom);
      end
   end

   function automatic logic needs_room(input logic [3:0] op);
      return (op == 4'h2) || (op == 4'h3);
   endfunction

   // Interpret one consumed word and schedule the bus/TPC events it must produce.
   task automatic consume(input logic [63:0] w, input logic [15:0] st);
      logic [63:0] a;
      a = {48'h0, w[ABITS+31:32]};
      if (want_data) begin
         exp_w.push_back('{c: cyc + 1, a: wr_addr, d: w});
         ref_mem[wr_addr[7:0]] = w;
         want_data = 1'b0;
         ready_cyc = cyc + 2;
      end else begin
         case (w[63:60])
            4'h1: begin
               wr_addr   = a;
               want_data = 1'b1;
               ready_cyc = cyc + 1;
            end
            4'h2: begin
               exp_r.push_back('{c: cyc + 1, a: a, d: 64'h0});
               exp_t.push_back('{c: cyc + RLAT + 2, a: 64'h0, d: ref_mem[a[7:0]]});
               ready_cyc = cyc + RLAT + 3;
            end
            4'h3: begin
               exp_t.push_back('{c: cyc + 1, a: 64'h0, d: {48'h0, st}});
               ready_cyc = cyc + 2;
            end
            4'h4: ready_cyc = cyc + 1 + ((w[31:0] == 32'd0) ? 1 : int'(w[31:0]));
            default: ready_cyc = cyc + 1;
         endcase
      end
   endtask

   initial begin
      logic exp_rd;
      logic hit;
      for (int i = 0; i < 256; i++) ref_mem[i] = 64'h0;
      forever begin
         @(negedge clock);
         if (reset) begin
            chk("rst_strobes", {60'h0, bus.fpc_read, bus.tpc_write, bus.rvalid, bus.wvalid}, 64'h0);
            chk("rst_addr", {48'h0, bus.address}, 64'h0);
            chk("rst_tpc_data", bus.tpc_data, 64'h0);
            chk("rst_wdata", bus.wdata, 64'h0);
            exp_w.delete();
            exp_r.delete();
            exp_t.delete();
            want_data = 1'b0;
            ready_cyc = 0;
         end else begin
            exp_rd = bus.fpc_valid && (cyc >= ready_cyc) &&
                     (want_data || !needs_room(bus.fpc_data[63:60]) || bus.tpc_ready);
            chk("fpc_read", {63'h0, bus.fpc_read}, {63'h0, exp_rd});

            hit = (exp_w.size() != 0) && (exp_w[0].c == cyc);
            chk("wvalid", {63'h0, bus.wvalid}, {63'h0, hit});
            if (hit) begin
               if (bus.wvalid) begin
                  chk("w_addr", {48'h0, bus.address}, exp_w[0].a);
                  chk("w_data", bus.wdata, exp_w[0].d);
               end
               void'(exp_w.pop_front());
            end

            hit = (exp_r.size() != 0) && (exp_r[0].c == cyc);
            chk("rvalid", {63'h0, bus.rvalid}, {63'h0, hit});
            if (hit) begin
               if (bus.rvalid) chk("r_addr", {48'h0, bus.address}, exp_r[0].a);
               void'(exp_r.pop_front());
            end

            hit = (exp_t.size() != 0) && (exp_t[0].c == cyc);
            chk("tpc_write", {63'h0, bus.tpc_write}, {63'h0, hit});
            if (hit) begin
               if (bus.tpc_write) chk("tpc_data", bus.tpc_data, exp_t[0].d);
               void'(exp_t.pop_front());
            end
            if (bus.tpc_write) push_log.push_back(bus.tpc_data);

            if (bus.fpc_valid && bus.fpc_read) begin
               cons_cyc.push_back(cyc);
               consume(bus.fpc_data, bus.status);
               if (src_q.size() != 0) void'(src_q.pop_front());
            end
         end
      end
   end

   task automatic drain(input int max);
      int k;
      k = 0;
      while ((src_q.size() != 0 || exp_w.size() != 0 || exp_r.size() != 0 ||
              exp_t.size() != 0 || cyc < ready_cyc + 1) && k < max) begin
         @(posedge clock);
         k++;
      end
      chk("drain_in_time", {63'h0, k < max}, 64'h1);
      repeat (2) @(posedge clock);
      #2;
   endtask

   function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] a, input logic [31:0] arg);
      return {op, 12'h0, a, arg};
   endfunction

   initial begin
      int n0;
      int c0;
      int k;

      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (5) @(posedge clock);
      #2;
      chk("idle_addr", {48'h0, bus.address}, 64'h0);
      chk("idle_tpc_data", bus.tpc_data, 64'h0);

      src_q.push_back(64'h1000_0000_0000_0000);
      src_q.push_back(64'hDEAD_BEEF_0123_4567);
      drain(100);
      chk("wr_wdata", bus.wdata, 64'hDEAD_BEEF_0123_4567);
      chk("wr_addr0", {48'h0, bus.address}, 64'h0);
      n0 = push_log.size();
      src_q.push_back(64'h2000_0000_0000_0000);
      drain(100);
      chk("rd0_count", 64'(push_log.size() - n0), 64'd1);
      chk("rd0_data", (push_log.size() > n0) ? push_log[n0] : 64'h0, 64'hDEAD_BEEF_0123_4567);

      rdy_pct = 0;
      n0 = push_log.size();
      src_q.push_back(mk(4'h2, 16'd5, 32'd0));
      repeat (8) @(posedge clock);
      #2;
      chk("rd5_held", 64'(src_q.size()), 64'd1);
      rdy_pct = 100;
      drain(100);
      chk("rd5_addr", {48'h0, bus.address}, 64'd5);
      chk("rd5_count", 64'(push_log.size() - n0), 64'd1);

      st_force = 1'b1;
      n0 = push_log.size();
      src_q.push_back(mk(4'h3, 16'd0, 32'd0));
      drain(100);
      st_force = 1'b0;
      chk("status_count", 64'(push_log.size() - n0), 64'd1);
      chk("status_data", (push_log.size() > n0) ? push_log[n0] : 64'h0, 64'h0000_0000_0000_A5C3);

      cons_cyc.delete();
      src_q.push_back(mk(4'h4, 16'd0, 32'd10));
      src_q.push_back(mk(4'h0, 16'd0, 32'd0));
      drain(100);
      chk("delay10_gap", (cons_cyc.size() >= 2) ? 64'(cons_cyc[1] - cons_cyc[0]) : 64'h0, 64'd11);
      cons_cyc.delete();
      src_q.push_back(mk(4'h4, 16'd0, 32'd0));
      src_q.push_back(mk(4'h0, 16'd0, 32'd0));
      drain(100);
      chk("delay0_gap", (cons_cyc.size() >= 2) ? 64'(cons_cyc[1] - cons_cyc[0]) : 64'h0, 64'd2);

      n0 = push_log.size();
      c0 = cons_cyc.size();
      src_q.push_back(mk(4'h2, 16'd3, 32'd0));
      k = 0;
      while (cons_cyc.size() == c0 && k < 50) begin
         @(posedge clock);
         k++;
      end
      chk("rwait_reached", {63'h0, k < 50}, 64'h1);
      #2 reset = 1'b1;
      src_q.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (8) @(posedge clock);
      #2;
      chk("rst_no_push", 64'(push_log.size() - n0), 64'd0);

      n0 = push_log.size();
      for (int i = 0; i < 4; i++) begin
         src_q.push_back(mk(4'h1, 16'(i), 32'd0));
         src_q.push_back(64'hC0DE_0000_0000_0000 + 64'(i));
         src_q.push_back(mk(4'h2, 16'(i), 32'd0));
      end
      drain(300);
      chk("pairs_count", 64'(push_log.size() - n0), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("pair_data", (push_log.size() > n0 + i) ? push_log[n0 + i] : 64'h0,
             64'hC0DE_0000_0000_0000 + 64'(i));

      vld_pct = 75;
      rdy_pct = 60;
      for (int n = 0; n < 250; n++) begin
         int unsigned sel;
         logic [15:0] a;
         logic [11:0] junk;
         logic [31:0] arg;
         sel  = $urandom_range(9);
         a    = 16'($urandom_range(15));
         junk = 12'($urandom);
         arg  = $urandom;
         case (sel)
            0, 1: src_q.push_back({4'h0, junk, a, arg});
            2, 3: begin
               src_q.push_back({4'h1, junk, a, arg});
               src_q.push_back({$urandom, $urandom});
            end
            4, 5, 6: src_q.push_back({4'h2, junk, a, arg});
            7: src_q.push_back({4'h3, junk, a, arg});
            8: src_q.push_back({4'h4, junk, a, 32'($urandom_range(5))});
            default: src_q.push_back({4'($urandom_range(15, 5)), junk, a, arg});
         endcase
      end
      drain(20000);
      vld_pct = 100;
      rdy_pct = 100;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
